// File: rtl/fft64_out_buffer.sv
// Capture stage for the USFFT64 result port: a ping-pong frame buffer that replays each
// completed frame in natural bin order over a valid/ready stream.
//
// Write FSM
//   state  | meaning
//   W_IDLE | waiting for a frame-start beat (ED & RDY)
//   W_FILL | storing beats of the current frame into the write bank
//   W_DROP | frame rejected (write bank still full); ignoring beats until next start
//
// Read FSM
//   state    | meaning
//   R_IDLE   | read bank not yet full
//   R_PREF   | fetching bin 0 of the read bank into the output register
//   R_STREAM | presenting registered beats downstream
module fft64_out_buffer #(
   parameter int DW = 19,
   parameter int AW = 6,
   parameter int CW = 8
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          ED,
   input  logic          RDY,
   input  logic          OVF1,
   input  logic          OVF2,
   input  logic [AW-1:0] ADDR,
   input  logic [DW-1:0] DOR,
   input  logic [DW-1:0] DOI,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [DW-1:0] m_re,
   output logic [DW-1:0] m_im,
   output logic [AW-1:0] m_idx,
   output logic          m_last,
   output logic          m_ovf,
   output logic [CW-1:0] drop_cnt,
   output logic          busy
);

   localparam int FRAME = 1 << AW;
   localparam logic [AW:0]   LAST_CNT = {1'b0, {AW{1'b1}}};
   localparam logic [AW-1:0] LAST_IDX = {AW{1'b1}};

   typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wstate_t;
   typedef enum logic [1:0] {R_IDLE, R_PREF, R_STREAM} rstate_t;

   wstate_t wstate;
   rstate_t rstate;

   logic [2*DW-1:0] mem [0:2*FRAME-1];

   logic          wbank;
   logic          rbank;
   logic [AW:0]   wcnt;
   logic          wovf;
   logic [1:0]    full;
   logic [1:0]    bank_ovf;

   logic          ovf_now;
   logic          wr_en;
   logic          frame_done;
   logic          drop_evt;
   logic          handshake;
   logic          release_bank;
   logic          rd_bank;
   logic [AW-1:0] rd_idx;
   logic [2*DW-1:0] rd_word;

   assign ovf_now = OVF1 | OVF2;

   // Full flags are the registered values, so a bank released this cycle still rejects a new frame.
   always_comb begin
      wr_en      = 1'b0;
      frame_done = 1'b0;
      drop_evt   = 1'b0;
      if (ED) begin
         if (RDY) begin
            wr_en    = ~full[wbank];
            drop_evt = full[wbank] | (wstate == W_FILL);
         end else if (wstate == W_FILL) begin
            wr_en      = 1'b1;
            frame_done = (wcnt == LAST_CNT);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (wr_en) begin
         mem[{wbank, ADDR}] <= {DOR, DOI};
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wstate   <= W_IDLE;
         wbank    <= 1'b0;
         wcnt     <= '0;
         wovf     <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (drop_evt && (drop_cnt != {CW{1'b1}})) begin
            drop_cnt <= drop_cnt + 1'b1;
         end
         if (ED) begin
            if (RDY) begin
               if (full[wbank]) begin
                  wstate <= W_DROP;
               end else begin
                  wstate <= W_FILL;
                  wcnt   <= {{AW{1'b0}}, 1'b1};
                  wovf   <= ovf_now;
               end
            end else if (wstate == W_FILL) begin
               if (frame_done) begin
                  wstate <= W_IDLE;
                  wbank  <= ~wbank;
                  wcnt   <= '0;
               end else begin
                  wcnt <= wcnt + 1'b1;
                  wovf <= wovf | ovf_now;
               end
            end
         end
      end
   end

   assign handshake    = m_valid & m_ready;
   assign release_bank = (rstate == R_STREAM) & handshake & m_last;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         full     <= 2'b00;
         bank_ovf <= 2'b00;
      end else begin
         if (frame_done) begin
            full[wbank]     <= 1'b1;
            bank_ovf[wbank] <= wovf | ovf_now;
         end
         if (release_bank) begin
            full[rbank] <= 1'b0;
         end
      end
   end

   // Next word to present: bin 0 on prefetch or bank switch, otherwise the following bin.
   always_comb begin
      rd_bank = rbank;
      rd_idx  = '0;
      if (rstate == R_STREAM) begin
         if (m_last) begin
            rd_bank = ~rbank;
         end else begin
            rd_idx = m_idx + 1'b1;
         end
      end
   end

   assign rd_word = mem[{rd_bank, rd_idx}];

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rstate  <= R_IDLE;
         rbank   <= 1'b0;
         m_valid <= 1'b0;
         m_re    <= '0;
         m_im    <= '0;
         m_idx   <= '0;
         m_last  <= 1'b0;
         m_ovf   <= 1'b0;
      end else begin
         case (rstate)
            R_IDLE: begin
               if (full[rbank]) begin
                  rstate <= R_PREF;
               end
            end
            R_PREF: begin
               m_valid <= 1'b1;
               m_re    <= rd_word[2*DW-1:DW];
               m_im    <= rd_word[DW-1:0];
               m_idx   <= rd_idx;
               m_last  <= (rd_idx == LAST_IDX);
               m_ovf   <= bank_ovf[rd_bank];
               rstate  <= R_STREAM;
            end
            R_STREAM: begin
               if (handshake) begin
                  if (m_last) begin
                     rbank <= ~rbank;
                  end
                  if (m_last && !full[~rbank]) begin
                     m_valid <= 1'b0;
                     rstate  <= R_IDLE;
                  end else begin
                     m_re   <= rd_word[2*DW-1:DW];
                     m_im   <= rd_word[DW-1:0];
                     m_idx  <= rd_idx;
                     m_last <= (rd_idx == LAST_IDX);
                     m_ovf  <= bank_ovf[rd_bank];
                  end
               end
            end
            default: rstate <= R_IDLE;
         endcase
      end
   end

   assign busy = (wstate == W_FILL) | (|full) | (rstate != R_IDLE);

endmodule

// File: tb/tb_fft64_out_buffer.sv
// Directed bench for fft64_out_buffer: single frame, bit-reversed capture, backpressure,
// overrun/drop, aborted frame and reset mid-stream.
module tb_fft64_out_buffer;

   localparam int DW = 19;
   localparam int AW = 6;
   localparam int CW = 8;

   logic          CLK;
   logic          RST;
   logic          ED;
   logic          RDY;
   logic          OVF1;
   logic          OVF2;
   logic [AW-1:0] ADDR;
   logic [DW-1:0] DOR;
   logic [DW-1:0] DOI;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_re;
   logic [DW-1:0] m_im;
   logic [AW-1:0] m_idx;
   logic          m_last;
   logic          m_ovf;
   logic [CW-1:0] drop_cnt;
   logic          busy;

   int n_tests = 0;
   int n_fail  = 0;

   fft64_out_buffer #(.DW(DW), .AW(AW), .CW(CW)) dut (
      .CLK(CLK), .RST(RST), .ED(ED), .RDY(RDY), .OVF1(OVF1), .OVF2(OVF2),
      .ADDR(ADDR), .DOR(DOR), .DOI(DOI),
      .m_valid(m_valid), .m_ready(m_ready), .m_re(m_re), .m_im(m_im),
      .m_idx(m_idx), .m_last(m_last), .m_ovf(m_ovf),
      .drop_cnt(drop_cnt), .busy(busy)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [AW-1:0] bitrev(input int i);
      logic [AW-1:0] v;
      logic [AW-1:0] r;
      v = AW'(i);
      for (int b = 0; b < AW; b++) r[b] = v[AW-1-b];
      return r;
   endfunction

   function automatic logic [63:0] obs();
      return 64'({m_idx, m_last, m_ovf, m_re, m_im});
   endfunction

   function automatic logic [63:0] expv(input int base, input int k, input bit ovf);
      logic [AW-1:0] idx;
      logic [DW-1:0] re;
      logic [DW-1:0] im;
      idx = AW'(k);
      re  = DW'(base + k);
      im  = DW'(-(base + k));
      return 64'({idx, (k == 63), ovf, re, im});
   endfunction

   function automatic bit ready_pat(input int mode, input int c);
      if (mode == 0) return 1'b1;
      if (c == 11 || c == 13) return 1'b0;
      if (c >= 20 && c <= 24) return 1'b0;
      return 1'b1;
   endfunction

   // Data for bin a of a frame is (base+a, -(base+a)).
   task automatic send_frame(input int base, input int nbeats, input bit rev, input int ovf_beat);
      for (int i = 0; i < nbeats; i++) begin
         ED   = 1'b1;
         RDY  = (i == 0);
         ADDR = rev ? bitrev(i) : AW'(i);
         DOR  = DW'(base + int'(ADDR));
         DOI  = DW'(-(base + int'(ADDR)));
         OVF2 = (i == ovf_beat);
         tick();
      end
      ED   = 1'b0;
      RDY  = 1'b0;
      OVF2 = 1'b0;
   endtask

   task automatic recv_frame(input int base, input bit exp_ovf, input int mode, input bit chk_gap);
      int k = 0;
      int c = 0;
      bit stalled = 1'b0;
      logic [63:0] held = '0;
      if (chk_gap) check("no_gap", 64'(m_valid), 64'd1);
      while (k < 64 && c < 300) begin
         m_ready = ready_pat(mode, c);
         if (stalled) check("stall_hold", obs(), held);
         stalled = 1'b0;
         if (m_valid) begin
            if (m_ready) begin
               check("beat", obs(), expv(base, k, exp_ovf));
               k++;
            end else begin
               stalled = 1'b1;
               held    = obs();
            end
         end
         tick();
         c++;
      end
      check("frame_count", 64'(k), 64'd64);
   endtask

   task automatic check_latency();
      check("lat_e0", 64'(m_valid), 64'd0);
      tick();
      check("lat_e1", 64'(m_valid), 64'd0);
      tick();
      check("lat_e2", 64'(m_valid), 64'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, 64'(m_valid), 64'd0);
      check({tag, "_data"}, 64'({m_re, m_im}), 64'd0);
      check({tag, "_idx"}, 64'({m_idx, m_last, m_ovf}), 64'd0);
      check({tag, "_drop"}, 64'(drop_cnt), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
   endtask

   initial begin
      int waited;
      RST = 1'b0; ED = 1'b0; RDY = 1'b0; OVF1 = 1'b0; OVF2 = 1'b0;
      ADDR = '0; DOR = '0; DOI = '0; m_ready = 1'b0;
      repeat (3) tick();
      check_reset_outputs("reset");
      RST = 1'b1;
      tick();

      // single linear frame
      m_ready = 1'b1;
      send_frame(0, 64, 1'b0, -1);
      check_latency();
      check("busy_stream", 64'(busy), 64'd1);
      recv_frame(0, 1'b0, 0, 1'b0);
      check("drop_single", 64'(drop_cnt), 64'd0);
      check("busy_idle", 64'(busy), 64'd0);

      // bit-reversed capture with an overflow on one beat
      send_frame(100, 64, 1'b1, 10);
      recv_frame(100, 1'b1, 0, 1'b0);

      // backpressure
      send_frame(200, 64, 1'b0, -1);
      recv_frame(200, 1'b0, 1, 1'b0);

      // overrun: third frame has nowhere to go
      m_ready = 1'b0;
      send_frame(300, 64, 1'b0, -1);
      send_frame(400, 64, 1'b0, -1);
      send_frame(500, 64, 1'b0, -1);
      repeat (3) tick();
      check("ovr_drop", 64'(drop_cnt), 64'd1);
      check("ovr_hold", obs(), expv(300, 0, 1'b0));
      recv_frame(300, 1'b0, 0, 1'b0);
      recv_frame(400, 1'b0, 0, 1'b1);
      check("ovr_empty", 64'(m_valid), 64'd0);

      // aborted partial frame followed by a full one
      send_frame(600, 20, 1'b0, -1);
      send_frame(700, 64, 1'b0, -1);
      check("abort_drop", 64'(drop_cnt), 64'd2);
      recv_frame(700, 1'b0, 0, 1'b0);

      // reset while streaming bin 30
      m_ready = 1'b1;
      send_frame(800, 64, 1'b0, -1);
      waited = 0;
      while (!(m_valid && m_idx == AW'(30)) && waited < 100) begin
         tick();
         waited++;
      end
      check("rst_reach30", 64'({m_valid, m_idx}), 64'({1'b1, 6'd30}));
      RST = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      tick();
      RST = 1'b1;
      tick();
      send_frame(900, 64, 1'b0, -1);
      check_latency();
      recv_frame(900, 1'b0, 0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
